// File: rtl/yapay_zeka_pkg.sv
// Shared definitions for the accelerator issue controller: op codes, FSM
// state encoding, default sizes and small load-accounting helpers.
package yapay_zeka_pkg;

  localparam int ELEMAN_SAYISI_VARSAYILAN = 16;
  localparam int ZAMAN_ASIMI_VARSAYILAN   = 64;

  typedef enum logic [2:0] {
    OP_NOP         = 3'b000,
    OP_FILTRE_RS1  = 3'b001,
    OP_FILTRE_RS12 = 3'b010,
    OP_VERI_RS1    = 3'b011,
    OP_VERI_RS12   = 3'b100,
    OP_FILTRE_SIL  = 3'b101,
    OP_VERI_SIL    = 3'b110,
    OP_CALISTIR    = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    BOSTA    = 2'b00,
    KOMUT    = 2'b01,
    CALISTIR = 2'b10,
    SONUC    = 2'b11
  } durum_e;

  // Number of matrix elements a load op pushes into the accelerator.
  function automatic logic [1:0] yuk_miktari(input op_e op);
    logic [1:0] miktar;
    miktar = 2'd0;
    case (op)
      OP_FILTRE_RS1, OP_VERI_RS1:   miktar = 2'd1;
      OP_FILTRE_RS12, OP_VERI_RS12: miktar = 2'd2;
      default:                      miktar = 2'd0;
    endcase
    return miktar;
  endfunction

  function automatic logic tasma_var(input logic [4:0] sayac,
                                     input logic [1:0] miktar,
                                     input int         sinir);
    return (int'(sayac) + int'(miktar)) > sinir;
  endfunction

endpackage

// File: rtl/yapay_zeka_denetleyici.sv
// Issue controller: accepts load/clear/run requests from the pipeline, drives
// one-cycle accelerator strobes and waits (with timeout) for the result.
module yapay_zeka_denetleyici
  import yapay_zeka_pkg::*;
#(
  parameter int ELEMAN_SAYISI = ELEMAN_SAYISI_VARSAYILAN,
  parameter int ZAMAN_ASIMI   = ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istek_gecerli_i,
  input  logic [2:0]  istek_op_i,
  input  logic [31:0] rs1_veri_i,
  input  logic [31:0] rs2_veri_i,
  output logic        istek_hazir_o,
  output logic        sonuc_gecerli_o,
  output logic [31:0] sonuc_o,
  output logic        hata_o,
  output logic        stall_o,
  output logic        blok_aktif_o,
  output logic [31:0] rs1_veri_o,
  output logic [31:0] rs2_veri_o,
  output logic        filtre_rs1_en_o,
  output logic        filtre_rs2_en_o,
  output logic        filtre_sil_o,
  output logic        veri_rs1_en_o,
  output logic        veri_rs2_en_o,
  output logic        veri_sil_o,
  output logic        conv_yap_en_o,
  input  logic [31:0] hiz_sonuc_i,
  input  logic        hiz_hazir_i
);

  localparam int BW = $clog2(ZAMAN_ASIMI + 1);

  durum_e      r_durum;
  op_e         r_op;
  logic [4:0]  r_filtre_sayac;
  logic [4:0]  r_veri_sayac;
  logic        r_calisti;
  logic [BW-1:0] r_bekleme;
  logic [31:0] r_sonuc;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic        r_filtre_rs1_en;
  logic        r_filtre_rs2_en;
  logic        r_filtre_sil;
  logic        r_veri_rs1_en;
  logic        r_veri_rs2_en;
  logic        r_veri_sil;
  logic        r_conv_yap_en;
  logic        r_hata;
  logic        r_sonuc_gecerli;
  logic        r_stall;

  op_e         w_op;
  logic        w_kabul;
  logic [1:0]  w_miktar;
  logic        w_filtre_tasma;
  logic        w_veri_tasma;
  logic        w_on_kontrol;

  assign w_op           = op_e'(istek_op_i);
  assign istek_hazir_o  = (r_durum == BOSTA) && !rst_i;
  assign w_kabul        = istek_gecerli_i && istek_hazir_o;
  assign w_miktar       = yuk_miktari(w_op);
  assign w_filtre_tasma = tasma_var(r_filtre_sayac, w_miktar, ELEMAN_SAYISI);
  assign w_veri_tasma   = tasma_var(r_veri_sayac, w_miktar, ELEMAN_SAYISI);
  // Counters are frozen during a run, so this stays valid for the whole wait.
  assign w_on_kontrol   = (r_filtre_sayac == r_veri_sayac) &&
                          (r_filtre_sayac != 5'd0) && (r_veri_sayac != 5'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_durum         <= BOSTA;
      r_op            <= OP_NOP;
      r_filtre_sayac  <= '0;
      r_veri_sayac    <= '0;
      r_calisti       <= 1'b0;
      r_bekleme       <= '0;
      r_sonuc         <= '0;
      r_rs1           <= '0;
      r_rs2           <= '0;
      r_filtre_rs1_en <= 1'b0;
      r_filtre_rs2_en <= 1'b0;
      r_filtre_sil    <= 1'b0;
      r_veri_rs1_en   <= 1'b0;
      r_veri_rs2_en   <= 1'b0;
      r_veri_sil      <= 1'b0;
      r_conv_yap_en   <= 1'b0;
      r_hata          <= 1'b0;
      r_sonuc_gecerli <= 1'b0;
      r_stall         <= 1'b0;
    end else begin
      r_filtre_rs1_en <= 1'b0;
      r_filtre_rs2_en <= 1'b0;
      r_filtre_sil    <= 1'b0;
      r_veri_rs1_en   <= 1'b0;
      r_veri_rs2_en   <= 1'b0;
      r_veri_sil      <= 1'b0;
      r_conv_yap_en   <= 1'b0;
      r_hata          <= 1'b0;
      r_sonuc_gecerli <= 1'b0;

      case (r_durum)
        // Strobes and rejections are decided here so they appear registered
        // in the KOMUT cycle; the counters follow one cycle later.
        BOSTA: begin
          if (w_kabul) begin
            r_op  <= w_op;
            r_rs1 <= rs1_veri_i;
            r_rs2 <= rs2_veri_i;
            case (w_op)
              OP_FILTRE_RS1, OP_FILTRE_RS12: begin
                r_durum <= KOMUT;
                r_stall <= 1'b1;
                if (r_calisti || w_filtre_tasma) begin
                  r_hata <= 1'b1;
                end else begin
                  r_filtre_rs1_en <= (w_op == OP_FILTRE_RS1);
                  r_filtre_rs2_en <= (w_op == OP_FILTRE_RS12);
                end
              end
              OP_VERI_RS1, OP_VERI_RS12: begin
                r_durum <= KOMUT;
                r_stall <= 1'b1;
                if (r_calisti || w_veri_tasma) begin
                  r_hata <= 1'b1;
                end else begin
                  r_veri_rs1_en <= (w_op == OP_VERI_RS1);
                  r_veri_rs2_en <= (w_op == OP_VERI_RS12);
                end
              end
              OP_FILTRE_SIL: begin
                r_durum      <= KOMUT;
                r_stall      <= 1'b1;
                r_filtre_sil <= 1'b1;
              end
              OP_VERI_SIL: begin
                r_durum    <= KOMUT;
                r_stall    <= 1'b1;
                r_veri_sil <= 1'b1;
              end
              OP_CALISTIR: begin
                r_durum       <= CALISTIR;
                r_stall       <= 1'b1;
                r_bekleme     <= '0;
                r_conv_yap_en <= w_on_kontrol;
              end
              default: begin
              end
            endcase
          end
        end

        KOMUT: begin
          r_durum <= BOSTA;
          r_stall <= 1'b0;
          if (!r_hata) begin
            case (r_op)
              OP_FILTRE_RS1, OP_FILTRE_RS12:
                r_filtre_sayac <= r_filtre_sayac + 5'(yuk_miktari(r_op));
              OP_VERI_RS1, OP_VERI_RS12:
                r_veri_sayac <= r_veri_sayac + 5'(yuk_miktari(r_op));
              OP_FILTRE_SIL: begin
                r_filtre_sayac <= '0;
                r_calisti      <= 1'b0;
              end
              OP_VERI_SIL: begin
                r_veri_sayac <= '0;
                r_calisti    <= 1'b0;
              end
              default: begin
              end
            endcase
          end
        end

        // A failed precheck or a timeout both report a zero result with hata.
        CALISTIR: begin
          if (!w_on_kontrol) begin
            r_sonuc         <= '0;
            r_hata          <= 1'b1;
            r_sonuc_gecerli <= 1'b1;
            r_stall         <= 1'b0;
            r_durum         <= SONUC;
          end else if (hiz_hazir_i) begin
            r_sonuc         <= hiz_sonuc_i;
            r_sonuc_gecerli <= 1'b1;
            r_stall         <= 1'b0;
            r_durum         <= SONUC;
          end else if (r_bekleme == BW'(ZAMAN_ASIMI - 1)) begin
            r_sonuc         <= '0;
            r_hata          <= 1'b1;
            r_sonuc_gecerli <= 1'b1;
            r_stall         <= 1'b0;
            r_durum         <= SONUC;
          end else begin
            r_bekleme     <= r_bekleme + BW'(1);
            r_conv_yap_en <= 1'b1;
          end
        end

        SONUC: begin
          r_calisti <= 1'b1;
          r_bekleme <= '0;
          r_durum   <= BOSTA;
        end

        default: r_durum <= BOSTA;
      endcase
    end
  end

  assign sonuc_gecerli_o = r_sonuc_gecerli;
  assign sonuc_o         = r_sonuc;
  assign hata_o          = r_hata;
  assign stall_o         = r_stall || (w_kabul && (w_op == OP_CALISTIR));
  assign blok_aktif_o    = !rst_i;
  assign rs1_veri_o      = r_rs1;
  assign rs2_veri_o      = r_rs2;
  assign filtre_rs1_en_o = r_filtre_rs1_en;
  assign filtre_rs2_en_o = r_filtre_rs2_en;
  assign filtre_sil_o    = r_filtre_sil;
  assign veri_rs1_en_o   = r_veri_rs1_en;
  assign veri_rs2_en_o   = r_veri_rs2_en;
  assign veri_sil_o      = r_veri_sil;
  assign conv_yap_en_o   = r_conv_yap_en;

endmodule

// File: tb/tb_yapay_zeka_denetleyici.sv
// Directed bench for yapay_zeka_denetleyici: a table of single-op vectors
// followed by hand-written run, mismatch, timeout and reset sequences.
module tb_yapay_zeka_denetleyici;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        istek_gecerli_i = 1'b0;
  logic [2:0]  istek_op_i = 3'b000;
  logic [31:0] rs1_veri_i = '0;
  logic [31:0] rs2_veri_i = '0;
  logic        istek_hazir_o;
  logic        sonuc_gecerli_o;
  logic [31:0] sonuc_o;
  logic        hata_o;
  logic        stall_o;
  logic        blok_aktif_o;
  logic [31:0] rs1_veri_o;
  logic [31:0] rs2_veri_o;
  logic        filtre_rs1_en_o;
  logic        filtre_rs2_en_o;
  logic        filtre_sil_o;
  logic        veri_rs1_en_o;
  logic        veri_rs2_en_o;
  logic        veri_sil_o;
  logic        conv_yap_en_o;
  logic [31:0] hiz_sonuc_i = '0;
  logic        hiz_hazir_i = 1'b0;

  yapay_zeka_denetleyici dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .istek_gecerli_i (istek_gecerli_i),
    .istek_op_i      (istek_op_i),
    .rs1_veri_i      (rs1_veri_i),
    .rs2_veri_i      (rs2_veri_i),
    .istek_hazir_o   (istek_hazir_o),
    .sonuc_gecerli_o (sonuc_gecerli_o),
    .sonuc_o         (sonuc_o),
    .hata_o          (hata_o),
    .stall_o         (stall_o),
    .blok_aktif_o    (blok_aktif_o),
    .rs1_veri_o      (rs1_veri_o),
    .rs2_veri_o      (rs2_veri_o),
    .filtre_rs1_en_o (filtre_rs1_en_o),
    .filtre_rs2_en_o (filtre_rs2_en_o),
    .filtre_sil_o    (filtre_sil_o),
    .veri_rs1_en_o   (veri_rs1_en_o),
    .veri_rs2_en_o   (veri_rs2_en_o),
    .veri_sil_o      (veri_sil_o),
    .conv_yap_en_o   (conv_yap_en_o),
    .hiz_sonuc_i     (hiz_sonuc_i),
    .hiz_hazir_i     (hiz_hazir_i)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] S_YOK  = 7'b0000000;
  localparam logic [6:0] S_FRS1 = 7'b1000000;
  localparam logic [6:0] S_FRS2 = 7'b0100000;
  localparam logic [6:0] S_FSIL = 7'b0010000;
  localparam logic [6:0] S_VRS1 = 7'b0001000;
  localparam logic [6:0] S_VRS2 = 7'b0000100;
  localparam logic [6:0] S_VSIL = 7'b0000010;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [6:0]  strobe;
    logic        hata;
    logic [4:0]  filtre;
    logic [4:0]  veri;
  } vektor_t;

  vektor_t tablo[$];
  int toplam = 0;
  int gecen  = 0;

  function automatic vektor_t satir(input logic [2:0] op, input logic [31:0] rs1,
                                    input logic [6:0] strobe, input logic hata,
                                    input logic [4:0] filtre, input logic [4:0] veri);
    vektor_t v;
    v.op = op; v.rs1 = rs1; v.strobe = strobe; v.hata = hata;
    v.filtre = filtre; v.veri = veri;
    return v;
  endfunction

  function automatic logic [6:0] strobelar();
    return {filtre_rs1_en_o, filtre_rs2_en_o, filtre_sil_o, veri_rs1_en_o,
            veri_rs2_en_o, veri_sil_o, conv_yap_en_o};
  endfunction

  task automatic tik();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string ad, input logic [31:0] gercek,
                             input logic [31:0] beklenen);
    toplam++;
    if (gercek === beklenen) gecen++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", ad, gercek, beklenen);
  endtask

  // Presents one request for one cycle; returns in the cycle after acceptance.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs1,
                               input logic [31:0] rs2);
    istek_gecerli_i = 1'b1;
    istek_op_i      = op;
    rs1_veri_i      = rs1;
    rs2_veri_i      = rs2;
    tik();
    istek_gecerli_i = 1'b0;
    istek_op_i      = 3'b000;
  endtask

  task automatic yukle(input logic [2:0] op);
    applyStimulus(op, 32'h11, 32'h22);
    tik();
  endtask

  initial begin
    int n;
    int bozuk;
    int erken;

    tablo.push_back(satir(3'b011, 32'h5,  S_VRS1, 1'b0, 5'd0,  5'd1));
    tablo.push_back(satir(3'b001, 32'hA,  S_FRS1, 1'b0, 5'd1,  5'd1));
    tablo.push_back(satir(3'b010, 32'hB,  S_FRS2, 1'b0, 5'd3,  5'd1));
    tablo.push_back(satir(3'b100, 32'hC,  S_VRS2, 1'b0, 5'd3,  5'd3));
    tablo.push_back(satir(3'b000, 32'hD,  S_YOK,  1'b0, 5'd3,  5'd3));
    tablo.push_back(satir(3'b101, 32'hE,  S_FSIL, 1'b0, 5'd0,  5'd3));
    tablo.push_back(satir(3'b110, 32'hF,  S_VSIL, 1'b0, 5'd0,  5'd0));
    for (int k = 1; k <= 7; k++)
      tablo.push_back(satir(3'b010, 32'h100 + k, S_FRS2, 1'b0, 5'(2 * k), 5'd0));
    tablo.push_back(satir(3'b001, 32'h200, S_FRS1, 1'b0, 5'd15, 5'd0));
    tablo.push_back(satir(3'b010, 32'h201, S_YOK,  1'b1, 5'd15, 5'd0));
    tablo.push_back(satir(3'b001, 32'h202, S_FRS1, 1'b0, 5'd16, 5'd0));
    tablo.push_back(satir(3'b001, 32'h203, S_YOK,  1'b1, 5'd16, 5'd0));
    tablo.push_back(satir(3'b011, 32'h204, S_VRS1, 1'b0, 5'd16, 5'd1));
    tablo.push_back(satir(3'b100, 32'h205, S_VRS2, 1'b0, 5'd16, 5'd3));
    tablo.push_back(satir(3'b101, 32'h206, S_FSIL, 1'b0, 5'd0,  5'd3));
    tablo.push_back(satir(3'b110, 32'h207, S_VSIL, 1'b0, 5'd0,  5'd0));

    // Reset state.
    #2;
    checkOutput("reset hazir", 32'(istek_hazir_o), 32'd0);
    checkOutput("reset blok_aktif", 32'(blok_aktif_o), 32'd0);
    checkOutput("reset strobes", 32'(strobelar()), 32'd0);
    checkOutput("reset stall", 32'(stall_o), 32'd0);
    checkOutput("reset sonuc", sonuc_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    checkOutput("release hazir", 32'(istek_hazir_o), 32'd1);
    checkOutput("release blok_aktif", 32'(blok_aktif_o), 32'd1);
    tik();

    // Single-op vectors.
    foreach (tablo[i]) begin
      applyStimulus(tablo[i].op, tablo[i].rs1, ~tablo[i].rs1);
      checkOutput($sformatf("v%0d strobe", i), 32'(strobelar()), 32'(tablo[i].strobe));
      checkOutput($sformatf("v%0d hata", i), 32'(hata_o), 32'(tablo[i].hata));
      checkOutput($sformatf("v%0d rs1", i), rs1_veri_o, tablo[i].rs1);
      checkOutput($sformatf("v%0d rs2", i), rs2_veri_o, ~tablo[i].rs1);
      checkOutput($sformatf("v%0d stall", i), 32'(stall_o), 32'(tablo[i].op != 3'b000));
      tik();
      checkOutput($sformatf("v%0d hazir", i), 32'(istek_hazir_o), 32'd1);
      checkOutput($sformatf("v%0d filtre_sayac", i), 32'(dut.r_filtre_sayac), 32'(tablo[i].filtre));
      checkOutput($sformatf("v%0d veri_sayac", i), 32'(dut.r_veri_sayac), 32'(tablo[i].veri));
    end

    // Mismatched counters: 4 filter elements, 3 data elements.
    yukle(3'b010); yukle(3'b010); yukle(3'b100); yukle(3'b011);
    istek_gecerli_i = 1'b1;
    istek_op_i = 3'b111;
    #1;
    checkOutput("mis stall on accept", 32'(stall_o), 32'd1);
    tik();
    istek_gecerli_i = 1'b0;
    istek_op_i = 3'b000;
    checkOutput("mis no conv", 32'(conv_yap_en_o), 32'd0);
    checkOutput("mis stall", 32'(stall_o), 32'd1);
    tik();
    checkOutput("mis gecerli", 32'(sonuc_gecerli_o), 32'd1);
    checkOutput("mis hata", 32'(hata_o), 32'd1);
    checkOutput("mis sonuc", sonuc_o, 32'd0);
    checkOutput("mis stall in sonuc", 32'(stall_o), 32'd0);
    tik();
    checkOutput("mis gecerli pulse", 32'(sonuc_gecerli_o), 32'd0);
    checkOutput("mis hazir", 32'(istek_hazir_o), 32'd1);
    applyStimulus(3'b001, 32'h1, 32'h2);
    checkOutput("load after run hata", 32'(hata_o), 32'd1);
    checkOutput("load after run strobe", 32'(strobelar()), 32'(S_YOK));
    tik();
    yukle(3'b101); yukle(3'b110);

    // Full run: 16 elements each, accelerator answers after 20 cycles.
    for (int k = 0; k < 8; k++) begin yukle(3'b010); yukle(3'b100); end
    checkOutput("full filtre_sayac", 32'(dut.r_filtre_sayac), 32'd16);
    applyStimulus(3'b111, 32'h0, 32'h0);
    bozuk = 0;
    erken = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(stall_o && conv_yap_en_o)) bozuk++;
      if (sonuc_gecerli_o) erken++;
      if (i == 19) begin hiz_hazir_i = 1'b1; hiz_sonuc_i = 32'h1234; end
      tik();
    end
    hiz_hazir_i = 1'b0;
    hiz_sonuc_i = 32'h0;
    checkOutput("run wait stall+conv", 32'(bozuk), 32'd0);
    checkOutput("run early result", 32'(erken), 32'd0);
    checkOutput("run gecerli", 32'(sonuc_gecerli_o), 32'd1);
    checkOutput("run sonuc", sonuc_o, 32'h1234);
    checkOutput("run hata", 32'(hata_o), 32'd0);
    checkOutput("run stall in sonuc", 32'(stall_o), 32'd0);
    tik();
    checkOutput("run gecerli pulse", 32'(sonuc_gecerli_o), 32'd0);
    repeat (3) tik();
    checkOutput("run sonuc hold", sonuc_o, 32'h1234);

    // Timeout: the accelerator never answers.
    applyStimulus(3'b111, 32'h0, 32'h0);
    n = 0;
    while (!sonuc_gecerli_o && n < 100) begin
      if (conv_yap_en_o && stall_o) n++;
      tik();
    end
    checkOutput("timeout wait cycles", 32'(n), 32'd64);
    checkOutput("timeout gecerli", 32'(sonuc_gecerli_o), 32'd1);
    checkOutput("timeout hata", 32'(hata_o), 32'd1);
    checkOutput("timeout sonuc", sonuc_o, 32'd0);
    tik();
    applyStimulus(3'b010, 32'h3, 32'h4);
    checkOutput("post-timeout load hata", 32'(hata_o), 32'd1);
    tik();
    checkOutput("post-timeout filtre kept", 32'(dut.r_filtre_sayac), 32'd16);
    applyStimulus(3'b101, 32'h0, 32'h0);
    checkOutput("clear filtre_sil", 32'(strobelar()), 32'(S_FSIL));
    tik();
    checkOutput("clear filtre_sayac", 32'(dut.r_filtre_sayac), 32'd0);
    checkOutput("clear calisti", 32'(dut.r_calisti), 32'd0);
    applyStimulus(3'b001, 32'h7, 32'h8);
    checkOutput("load after clear strobe", 32'(strobelar()), 32'(S_FRS1));
    checkOutput("load after clear hata", 32'(hata_o), 32'd0);
    tik();

    // Reset in the middle of a run.
    yukle(3'b110); yukle(3'b011);
    applyStimulus(3'b111, 32'h0, 32'h0);
    repeat (9) tik();
    checkOutput("pre-reset conv", 32'(conv_yap_en_o), 32'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("midrun reset strobes", 32'(strobelar()), 32'd0);
    checkOutput("midrun reset stall", 32'(stall_o), 32'd0);
    checkOutput("midrun reset hazir", 32'(istek_hazir_o), 32'd0);
    checkOutput("midrun reset blok_aktif", 32'(blok_aktif_o), 32'd0);
    checkOutput("midrun reset rs1", rs1_veri_o, 32'd0);
    tik();
    rst_i = 1'b0;
    #1;
    erken = 0;
    for (int i = 0; i < 4; i++) begin
      if (sonuc_gecerli_o) erken++;
      tik();
    end
    checkOutput("post-reset no gecerli", 32'(erken), 32'd0);
    checkOutput("post-reset hazir", 32'(istek_hazir_o), 32'd1);
    checkOutput("post-reset blok_aktif", 32'(blok_aktif_o), 32'd1);
    checkOutput("post-reset veri_sayac", 32'(dut.r_veri_sayac), 32'd0);

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule

// File: doc/yapay_zeka_denetleyici.md
YAPAY_ZEKA_DENETLEYICI -- requirements
Module: yapay_zeka_denetleyici

Interface
REQ-001 Parameter: ELEMAN_SAYISI, 16, matrix depth per operand.
REQ-002 Parameter: ZAMAN_ASIMI, 64, maximum wait cycles for a convolution result.
REQ-003 Port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_i  input  1  reset, asynchronous and active-high.
REQ-005 Port: istek_gecerli_i  input  1  the pipeline presents an accelerator operation.
REQ-006 Port: istek_op_i  input  3  operation code:
- 001 filter load, rs1
- 010 filter load, rs1+rs2
- 011 data load, rs1
- 100 data load, rs1+rs2
- 101 filter clear
- 110 data clear
- 111 run
- 000 no-op.
REQ-007 Port: rs1_veri_i / rs2_veri_i  input  32 each  operand values.
REQ-008 Port: istek_hazir_o  output  1  the controller can accept a request.
REQ-009 Port: sonuc_gecerli_o  output  1  one-cycle pulse; sonuc_o is valid.
REQ-010 Port: sonuc_o  output  32  convolution result.
REQ-011 Port: hata_o  output  1  one-cycle pulse marking a rejected or failed operation.
REQ-012 Port: stall_o  output  1  freezes the pipeline while the controller is busy.
REQ-013 Port: blok_aktif_o  output  1  accelerator enable.
REQ-014 Port: rs1_veri_o / rs2_veri_o  output  32 each  registered operands to the accelerator.
REQ-015 Port: filtre_rs1_en_o, filtre_rs2_en_o, filtre_sil_o, veri_rs1_en_o, veri_rs2_en_o, veri_sil_o, conv_yap_en_o  output  1 each  accelerator command strobes.
REQ-016 Port: hiz_sonuc_i  input  32  accelerator result.
REQ-017 Port: hiz_hazir_i  input  1  accelerator result ready.

Function
REQ-018 Acceptance: a request SHALL be accepted only when istek_gecerli_i=1 and istek_hazir_o=1; istek_hazir_o SHALL be 1 only in state BOSTA.
REQ-019 FSM states SHALL be BOSTA, KOMUT, CALISTIR, SONUC.
REQ-020 BOSTA SHALL go to KOMUT on acceptance of an op other than run or no-op.
REQ-021 BOSTA SHALL go to CALISTIR on acceptance of run; an accepted no-op SHALL cause no state change.
REQ-022 On acceptance the controller SHALL register the op and both operands; rs1_veri_o and rs2_veri_o SHALL reflect these registers.
REQ-023 KOMUT SHALL assert exactly one enable/clear strobe for exactly one cycle, then return to BOSTA; a load accepted at cycle N gives its strobe at N+1 and istek_hazir_o=1 at N+2.
REQ-024 Load counters filtre_sayac and veri_sayac (5 bits) SHALL increase by 1 or 2 per load.
REQ-025 A load that would exceed ELEMAN_SAYISI SHALL assert no strobe, leave the counter unchanged and pulse hata_o in the KOMUT cycle; this includes a 2-element load at count 15.
REQ-026 A clear SHALL pulse the matching sil strobe, zero the matching counter and clear the calisti flag.
REQ-027 Once a run has completed (calisti=1), loads SHALL be rejected with hata_o until a clear is performed.
REQ-028 Run precheck in the first CALISTIR cycle: if filtre_sayac != veri_sayac or either counter is 0, the controller SHALL go to SONUC with sonuc_o=0 and hata_o=1, asserting no conv_yap_en_o.
REQ-029 While waiting in CALISTIR, conv_yap_en_o SHALL be 1 every cycle until hiz_hazir_i=1 is sampled.
REQ-030 On sampling hiz_hazir_i=1 the controller SHALL capture hiz_sonuc_i and go to SONUC.
REQ-031 A wait counter SHALL time out after ZAMAN_ASIMI cycles in CALISTIR; on timeout the controller SHALL go to SONUC with sonuc_o=0 and hata_o=1.
REQ-032 SONUC SHALL pulse sonuc_gecerli_o for one cycle, set calisti, and return to BOSTA; sonuc_o SHALL hold its value until the next run.
REQ-033 stall_o SHALL be 1 in KOMUT and CALISTIR, and combinationally in BOSTA when a run is being accepted; it SHALL be 0 in SONUC.
REQ-034 blok_aktif_o SHALL be 1 whenever the controller is out of reset.
REQ-035 istek_gecerli_i SHALL be ignored outside BOSTA.

Reset
REQ-036 rst_i=1 SHALL asynchronously force:
- state BOSTA
- both counters 0, calisti 0, wait counter 0
- sonuc_o, rs1_veri_o, rs2_veri_o 0
- all strobes, hata_o, sonuc_gecerli_o and stall_o 0
- istek_hazir_o 1 after release.
REQ-037 A reset during CALISTIR SHALL abandon the run with no sonuc_gecerli_o pulse.

Structure
REQ-038 The op codes, the state encoding and the ELEMAN_SAYISI and ZAMAN_ASIMI defaults SHALL reside in a shared package, yapay_zeka_pkg.
REQ-039 The controller SHALL be a single module with no sub-modules.

Verification
REQ-040 Single load: accept op 011 with rs1=0x5 at cycle N -> veri_rs1_en_o=1 and rs1_veri_o=0x5 at N+1, veri_sayac=1.
REQ-041 Full run: 8 filter op-010 loads and 8 data op-100 loads, then run; the accelerator model raises hiz_hazir_i after 20 cycles with 0x1234 -> stall_o high throughout the wait, sonuc_gecerli_o for one cycle with sonuc_o=0x1234.
REQ-042 Overflow: filter count at 15, op 010 -> no strobe, hata_o pulse, filtre_sayac stays 15.
REQ-043 Mismatch: filter count 4, data count 3, run -> no conv_yap_en_o, sonuc_o=0, hata_o and sonuc_gecerli_o pulse together.
REQ-044 Timeout: hiz_hazir_i held 0 -> after 64 CALISTIR cycles sonuc_o=0 and hata_o=1; a load after the run -> hata_o, and a following op 101 -> filtre_sil_o pulse, counter 0, calisti cleared.
REQ-045 Reset mid-run: rst_i at wait cycle 10 -> all outputs 0 immediately, no sonuc_gecerli_o, istek_hazir_o=1 after release.
